// File: rtl/imem_fetch_unit.sv
// Instruction-side fetch unit: holds the instruction store, returns one registered
// word per cycle, and handles core stall/clear, program preload, faults and counters.
module imem_fetch_unit #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          SQUASH_CNT = 2,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instr_addr,
    input  logic        instr_stall,
    input  logic        instr_clear,
    output logic [31:0] instr_in,
    output logic        instr_valid,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, SQUASH, FAULT} state_t;

    state_t      state, state_n;
    logic [2:0]  remaining, remaining_n;
    logic [31:0] instr_n, fault_addr_n, fetch_cnt_n, squash_cnt_n;
    logic        valid_n, fault_n;

    logic [31:0] mem [DEPTH];

    logic [31:0] fetch_off, ld_off;
    logic        fetch_ok, ld_ok;
    logic [AW-1:0] fetch_idx, ld_idx;

    assign fetch_off = instr_addr - BASE_ADDR;
    assign ld_off    = ld_addr - BASE_ADDR;
    assign fetch_ok  = (fetch_off[1:0] == 2'b00) && ({2'b00, fetch_off[31:2]} < 32'(DEPTH));
    assign ld_ok     = (ld_off[1:0] == 2'b00) && ({2'b00, ld_off[31:2]} < 32'(DEPTH));
    assign fetch_idx = fetch_off[AW+1:2];
    assign ld_idx    = ld_off[AW+1:2];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // NOTE: the instruction store carries no reset; only the control and output
    // registers below are reset, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok)
            mem[ld_idx] <= ld_data;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n      = state;
        remaining_n  = remaining;
        instr_n      = instr_in;
        valid_n      = instr_valid;
        fault_n      = fault;
        fault_addr_n = fault_addr;
        fetch_cnt_n  = fetch_cnt;
        squash_cnt_n = squash_cnt;

        unique case (state)
            IDLE: begin
                instr_n = NOP;
                valid_n = 1'b0;
                if (run)
                    state_n = RUN;
            end
            RUN: begin
                if (!run) begin
                    state_n = IDLE;
                    instr_n = NOP;
                    valid_n = 1'b0;
                end else if (instr_clear) begin
                    instr_n      = NOP;
                    valid_n      = 1'b0;
                    squash_cnt_n = sat_inc(squash_cnt);
                    remaining_n  = SQ_RELOAD;
                    state_n      = (SQ_RELOAD != 3'd0) ? SQUASH : RUN;
                end else if (instr_stall) begin
                    // hold the presented word; address is not inspected
                end else if (!fetch_ok) begin
                    state_n      = FAULT;
                    instr_n      = NOP;
                    valid_n      = 1'b0;
                    fault_n      = 1'b1;
                    fault_addr_n = instr_addr;
                end else begin
                    instr_n     = mem[fetch_idx];
                    valid_n     = 1'b1;
                    fetch_cnt_n = sat_inc(fetch_cnt);
                end
            end
            SQUASH: begin
                instr_n = NOP;
                valid_n = 1'b0;
                if (!run) begin
                    state_n     = IDLE;
                    remaining_n = 3'd0;
                end else if (instr_clear) begin
                    squash_cnt_n = sat_inc(squash_cnt);
                    remaining_n  = SQ_RELOAD;
                    if (SQ_RELOAD == 3'd0)
                        state_n = RUN;
                end else begin
                    squash_cnt_n = sat_inc(squash_cnt);
                    remaining_n  = remaining - 3'd1;
                    if (remaining == 3'd1)
                        state_n = RUN;
                end
            end
            FAULT: begin
                instr_n = NOP;
                valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= 3'd0;
            instr_in    <= NOP;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= 32'h0;
            fetch_cnt   <= 32'h0;
            squash_cnt  <= 32'h0;
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            instr_in    <= instr_n;
            instr_valid <= valid_n;
            fault       <= fault_n;
            fault_addr  <= fault_addr_n;
            fetch_cnt   <= fetch_cnt_n;
            squash_cnt  <= squash_cnt_n;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a behavioural model predicts each edge's
// outputs into a queue, and a monitor compares them after every rising edge.
module tb_imem_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          SQ    = 2;
    localparam logic [31:0] NOPW  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, run, instr_stall, instr_clear, ld_en;
    logic [31:0] instr_addr, ld_addr, ld_data;
    logic [31:0] instr_in, fault_addr, fetch_cnt, squash_cnt;
    logic        instr_valid, fault;

    imem_fetch_unit #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .SQUASH_CNT(SQ), .NOP(NOPW)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_addr(instr_addr),
        .instr_stall(instr_stall), .instr_clear(instr_clear),
        .instr_in(instr_in), .instr_valid(instr_valid),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fault(fault), .fault_addr(fault_addr),
        .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        flt;
        logic [31:0] faddr;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: activity flag, sticky fault, and a count of NOPs still owed.
    logic [31:0] mem_m [DEPTH];
    bit          m_active, m_faulted;
    int          m_nops;
    logic [31:0] m_instr, m_faddr, m_fcnt, m_scnt;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off % 4 == 0) && (off / 4 < DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_faulted = 0; m_nops = 0;
        m_instr = NOPW; m_valid = 0; m_faddr = 0; m_fcnt = 0; m_scnt = 0;
    endtask

    task automatic model_step();
        exp_t e;
        logic [31:0] old_word;
        old_word = in_range(instr_addr) ? mem_m[widx(instr_addr)] : NOPW;
        if (m_faulted) begin
            m_instr = NOPW; m_valid = 0;
        end else if (!m_active) begin
            m_instr = NOPW; m_valid = 0;
            if (run) m_active = 1;
        end else if (!run) begin
            m_active = 0; m_nops = 0; m_instr = NOPW; m_valid = 0;
        end else if (instr_clear) begin
            m_nops = SQ - 1; m_instr = NOPW; m_valid = 0; m_scnt = inc(m_scnt);
        end else if (m_nops > 0) begin
            m_nops--; m_instr = NOPW; m_valid = 0; m_scnt = inc(m_scnt);
        end else if (instr_stall) begin
            // word held
        end else if (!in_range(instr_addr)) begin
            m_faulted = 1; m_faddr = instr_addr; m_instr = NOPW; m_valid = 0;
        end else begin
            m_instr = old_word; m_valid = 1; m_fcnt = inc(m_fcnt);
        end
        if (ld_en && in_range(ld_addr))
            mem_m[widx(ld_addr)] = ld_data;
        e = '{m_instr, m_valid, m_faulted, m_faddr, m_fcnt, m_scnt};
        sb.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic [31:0] a, input logic st, input logic cl,
                         input logic le, input logic [31:0] la, input logic [31:0] ld);
        @(negedge clk);
        run = r; instr_addr = a; instr_stall = st; instr_clear = cl;
        ld_en = le; ld_addr = la; ld_data = ld;
        model_step();
    endtask

    task automatic fetch(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Reset is raised between edges so the outputs must change without any clock.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_instr", instr_in, NOPW);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_faddr", fault_addr, 32'h0);
        check("rst_fcnt", fetch_cnt, 32'h0);
        check("rst_scnt", squash_cnt, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run = 0; instr_stall = 0; instr_clear = 0; ld_en = 0;
        model_step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr_in", instr_in, e.instr);
                check("instr_valid", 32'(instr_valid), 32'(e.valid));
                check("fault", 32'(fault), 32'(e.flt));
                check("fault_addr", fault_addr, e.faddr);
                check("fetch_cnt", fetch_cnt, e.fcnt);
                check("squash_cnt", squash_cnt, e.scnt);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] w;
        reset = 1'b1; run = 0; instr_addr = 0; instr_stall = 0; instr_clear = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        model_reset();
        do_reset();

        // Preload the whole store, with the three program words at the bottom.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       w = 32'h2408_0005;
                1:       w = 32'h2409_0003;
                2:       w = 32'h0109_5021;
                default: w = $urandom;
            endcase
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i * 4), w);
        end

        // Basic fetch
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        @(posedge clk); #2;
        check("basic_word2", instr_in, 32'h0109_5021);
        check("basic_fetch_cnt", fetch_cnt, 32'd3);

        // Stall hold with a changing address, then the held address is fetched
        fetch(32'h4);
        repeat (3) cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'hC);

        // Squash with stall, then a second clear during SQUASH
        cycle(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        fetch(32'h14); fetch(32'h18); fetch(32'h1C);
        cycle(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        fetch(32'h28); fetch(32'h2C); fetch(32'h30);

        // Read-before-write to the same word
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
        fetch(32'h4);
        @(posedge clk); #2;
        check("rbw_new_word", instr_in, 32'hDEAD_BEEF);

        // Run drop, then resume
        cycle(1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h8);

        // Reset while in SQUASH
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        do_reset();
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h0);

        // Misaligned fault is sticky and ignores later valid fetches
        fetch(32'h6);
        repeat (3) fetch(32'h0);
        do_reset();
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'(DEPTH * 4));
        fetch(32'h4);
        do_reset();
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h8);
        cycle(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'hC);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r, st, cl, le;
            logic [31:0] a, la;
            r  = ($urandom_range(0, 19) != 0);
            st = ($urandom_range(0, 4) == 0);
            cl = ($urandom_range(0, 9) == 0);
            le = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) a = $urandom_range(0, DEPTH * 4 + 15);
            else                            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 3) == 0) la = $urandom_range(0, DEPTH * 4 + 15);
            else                           la = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            cycle(r, a, st, cl, le, la, $urandom);
            if (m_faulted && $urandom_range(0, 3) == 0)
                do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
